// File: rtl/rs_pkg.sv
// Shared types, defaults and helpers for the RS encoder front-end blocks.
package rs_pkg;

  typedef enum logic {
    DATA = 1'b0,
    PAD  = 1'b1
  } state_t;

  localparam int         K_MAX_DEF    = 229;
  localparam logic [7:0] PAD_BYTE_DEF = 8'h00;

  // Ceiling log2, usable in parameter defaults; clog2(1) is 0.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_word2byte.sv
// Single-word hold register that serialises a WORD_BYTES-wide word into bytes,
// with valid/ready on both sides and a selectable byte order.
module rs_word2byte
  import rs_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic                    core_clk,
  input  logic                    rst_n,
  input  logic                    in_enable,
  input  logic [8*WORD_BYTES-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int               IDX_W    = (WORD_BYTES > 1) ? clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  logic [8*WORD_BYTES-1:0] hold_word;
  logic                    hold_valid;
  logic [IDX_W-1:0]        byte_idx;
  logic                    last_byte;
  logic                    accept;
  logic                    pop;

  assign last_byte = (byte_idx == LAST_IDX);
  // A new word may land in the same cycle the previous word's final byte leaves.
  assign in_ready  = in_enable && (!hold_valid || (out_ready && last_byte));
  assign accept    = in_valid && in_ready;
  assign pop       = hold_valid && out_ready;
  assign out_valid = hold_valid;

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_word  <= '0;
      hold_valid <= 1'b0;
      byte_idx   <= '0;
    end else if (accept) begin
      hold_word  <= in_data;
      hold_valid <= 1'b1;
      byte_idx   <= '0;
    end else if (pop) begin
      if (last_byte) begin
        hold_valid <= 1'b0;
        byte_idx   <= '0;
      end else begin
        byte_idx <= byte_idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (byte_idx == IDX_W'(b)) begin
        out_data = BIG_ENDIAN ? hold_word[8*(WORD_BYTES-1-b) +: 8] : hold_word[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/rs_enc_framer.sv
// Word-to-byte framer for the RS encoder AXIS input: programmable block length,
// flush with pad bytes, block counter and saturating encoder error counter.
module rs_enc_framer
  import rs_pkg::*;
#(
  parameter int         WORD_BYTES = 4,
  parameter int         K_MAX      = K_MAX_DEF,
  parameter int         CNT_W      = clog2(K_MAX + 1),
  parameter bit         BIG_ENDIAN = 1'b0,
  parameter logic [7:0] PAD_BYTE   = PAD_BYTE_DEF
) (
  input  logic                    core_clk,
  input  logic                    rst_n,
  input  logic [CNT_W-1:0]        cfg_k,
  input  logic [8*WORD_BYTES-1:0] s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    flush_i,
  output logic [7:0]              m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic                    m_tlast,
  input  logic                    ev_tlast_missing_i,
  input  logic                    ev_tlast_unexpected_i,
  output logic [15:0]             err_cnt,
  output logic [31:0]             blk_cnt,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] K_MAX_C = CNT_W'(K_MAX);

  state_t           state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] k_act;
  logic [CNT_W-1:0] k_sel;
  logic             run;
  logic             accept_en;
  logic [7:0]       w2b_data;
  logic             w2b_valid;
  logic             at_last;
  logic             xfer;
  logic [16:0]      err_sum;

  // Held low through reset so every output reads 0 until the first clock.
  assign accept_en = run && (state_q == DATA) && !flush_pend_q;

  rs_word2byte #(
    .WORD_BYTES(WORD_BYTES),
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_word2byte (
    .core_clk (core_clk),
    .rst_n    (rst_n),
    .in_enable(accept_en),
    .in_data  (s_data),
    .in_valid (s_valid),
    .in_ready (s_ready),
    .out_data (w2b_data),
    .out_valid(w2b_valid),
    .out_ready(m_tready)
  );

  assign m_tvalid = (state_q == PAD) || w2b_valid;
  assign m_tdata  = (state_q == PAD) ? PAD_BYTE : w2b_data;
  assign at_last  = (byte_cnt == k_act - CNT_W'(1));
  assign m_tlast  = m_tvalid && at_last;
  assign xfer     = m_tvalid && m_tready;
  assign busy     = w2b_valid || (byte_cnt != '0) || flush_pend_q;
  assign k_sel    = ((cfg_k == '0) || (cfg_k > K_MAX_C)) ? K_MAX_C : cfg_k;
  assign err_sum  = {1'b0, err_cnt} + 17'(ev_tlast_missing_i) + 17'(ev_tlast_unexpected_i);

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DATA;
      flush_pend_q <= 1'b0;
      run          <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      run          <= 1'b1;
    end
  end

  // A flush only completes a block already in progress; an empty one is dropped.
  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      DATA: begin
        if (flush_pend_q && !w2b_valid) begin
          if (byte_cnt == '0) begin
            flush_pend_d = 1'b0;
          end else begin
            state_d = PAD;
          end
        end
        if (flush_i) begin
          flush_pend_d = 1'b1;
        end
      end
      PAD: begin
        if (xfer && at_last) begin
          state_d      = DATA;
          flush_pend_d = 1'b0;
        end
      end
      default: begin
        state_d      = DATA;
        flush_pend_d = 1'b0;
      end
    endcase
  end

  // Block length is only re-sampled while idle at a block boundary.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      k_act    <= K_MAX_C;
      blk_cnt  <= '0;
    end else begin
      if ((byte_cnt == '0) && !xfer) begin
        k_act <= k_sel;
      end
      if (xfer) begin
        if (at_last) begin
          byte_cnt <= '0;
          blk_cnt  <= blk_cnt + 32'd1;
        end else begin
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule

// File: tb/tb_rs_enc_framer.sv
// Self-checking bench for rs_enc_framer: little- and big-endian instances share
// stimulus and are checked every cycle against a byte-stream reference model.
module tb_rs_enc_framer;
  import rs_pkg::*;

  localparam int KMAX = 229;

  logic        core_clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cfg_k;
  logic [31:0] s_data;
  logic        s_valid, flush_i, m_tready, ev_m, ev_u;

  logic        s_ready_le, m_tvalid_le, m_tlast_le, busy_le;
  logic [7:0]  m_tdata_le;
  logic [15:0] err_cnt_le;
  logic [31:0] blk_cnt_le;
  logic        s_ready_be, m_tvalid_be, m_tlast_be, busy_be;
  logic [7:0]  m_tdata_be;
  logic [15:0] err_cnt_be;
  logic [31:0] blk_cnt_be;

  int vectors = 0;
  int miscompares = 0;

  byte unsigned q_le[$], q_be[$];
  int           m_pos, m_k, m_err;
  bit           m_fp, m_pad, m_run;
  int unsigned  m_blk;
  byte unsigned log_le[$], log_be[$];
  bit           log_last[$];
  longint       log_cyc[$];
  longint       cyc = 0;

  always #5 core_clk = ~core_clk;

  rs_enc_framer #(.BIG_ENDIAN(1'b0)) dut_le (
    .core_clk(core_clk), .rst_n(rst_n), .cfg_k(cfg_k), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready_le), .flush_i(flush_i),
    .m_tdata(m_tdata_le), .m_tvalid(m_tvalid_le), .m_tready(m_tready),
    .m_tlast(m_tlast_le), .ev_tlast_missing_i(ev_m), .ev_tlast_unexpected_i(ev_u),
    .err_cnt(err_cnt_le), .blk_cnt(blk_cnt_le), .busy(busy_le)
  );

  rs_enc_framer #(.BIG_ENDIAN(1'b1)) dut_be (
    .core_clk(core_clk), .rst_n(rst_n), .cfg_k(cfg_k), .s_data(s_data),
    .s_valid(s_valid), .s_ready(s_ready_be), .flush_i(flush_i),
    .m_tdata(m_tdata_be), .m_tvalid(m_tvalid_be), .m_tready(m_tready),
    .m_tlast(m_tlast_be), .ev_tlast_missing_i(ev_m), .ev_tlast_unexpected_i(ev_u),
    .err_cnt(err_cnt_be), .blk_cnt(blk_cnt_be), .busy(busy_be)
  );

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int k_of(input logic [7:0] c);
    return ((c == 8'd0) || (int'(c) > KMAX)) ? KMAX : int'(c);
  endfunction

  // Reference: accepted words become a byte queue; blocks are cut every k bytes.
  always @(negedge core_clk) begin
    bit exp_valid, exp_ready, exp_last, exp_busy, x, acc, pad_pre, qempty_pre;
    int pos_pre;
    byte unsigned exp_le, exp_be;
    cyc++;
    if (!rst_n) begin
      check_output("rst s_ready", s_ready_le, 0);
      check_output("rst m_tvalid", m_tvalid_le, 0);
      check_output("rst m_tdata", m_tdata_le, 0);
      check_output("rst m_tlast", m_tlast_le, 0);
      check_output("rst err_cnt", err_cnt_le, 0);
      check_output("rst blk_cnt", blk_cnt_le, 0);
      check_output("rst busy", busy_le, 0);
      check_output("rst be m_tvalid", m_tvalid_be, 0);
      check_output("rst be m_tdata", m_tdata_be, 0);
      q_le.delete(); q_be.delete();
      m_pos = 0; m_k = KMAX; m_fp = 0; m_pad = 0; m_run = 0; m_blk = 0; m_err = 0;
    end else begin
      exp_valid = m_pad || (q_le.size() > 0);
      exp_ready = m_run && !m_pad && !m_fp && ((q_le.size() == 0) || (m_tready && q_le.size() == 1));
      exp_last  = exp_valid && (m_pos == m_k - 1);
      exp_busy  = (q_le.size() > 0) || (m_pos != 0) || m_fp;
      check_output("m_tvalid", m_tvalid_le, exp_valid);
      check_output("be m_tvalid", m_tvalid_be, exp_valid);
      check_output("s_ready", s_ready_le, exp_ready);
      check_output("be s_ready", s_ready_be, exp_ready);
      check_output("busy", busy_le, exp_busy);
      check_output("blk_cnt", blk_cnt_le, m_blk);
      check_output("be blk_cnt", blk_cnt_be, m_blk);
      check_output("err_cnt", err_cnt_le, m_err);
      if (exp_valid) begin
        exp_le = m_pad ? PAD_BYTE_DEF : q_le[0];
        exp_be = m_pad ? PAD_BYTE_DEF : q_be[0];
        check_output("m_tdata", m_tdata_le, exp_le);
        check_output("be m_tdata", m_tdata_be, exp_be);
        check_output("m_tlast", m_tlast_le, exp_last);
        check_output("be m_tlast", m_tlast_be, exp_last);
      end
      if (m_tvalid_le && m_tready) begin
        log_le.push_back(m_tdata_le); log_be.push_back(m_tdata_be);
        log_last.push_back(m_tlast_le); log_cyc.push_back(cyc);
      end
      x = exp_valid && m_tready;
      acc = s_valid && exp_ready;
      pad_pre = m_pad; qempty_pre = (q_le.size() == 0); pos_pre = m_pos;
      if (m_pos == 0 && !x) m_k = k_of(cfg_k);
      if (x) begin
        if (!pad_pre) begin
          void'(q_le.pop_front()); void'(q_be.pop_front());
        end
        if (exp_last) begin
          m_pos = 0; m_blk++;
          if (pad_pre) begin m_pad = 0; m_fp = 0; end
        end else begin
          m_pos++;
        end
      end
      if (!pad_pre) begin
        if (m_fp && qempty_pre) begin
          if (pos_pre == 0) m_fp = 0; else m_pad = 1;
        end
        if (flush_i) m_fp = 1;
      end
      if (acc) begin
        for (int b = 0; b < 4; b++) begin
          q_le.push_back(s_data[8*b +: 8]);
          q_be.push_back(s_data[8*(3-b) +: 8]);
        end
      end
      m_err = m_err + int'(ev_m) + int'(ev_u);
      if (m_err > 65535) m_err = 65535;
      m_run = 1;
    end
  end

  task automatic tick();
    @(posedge core_clk); #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] w);
    bit done = 0;
    s_data = w; s_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge core_clk);
      done = s_ready_le;
      tick();
    end
    s_valid = 1'b0;
    if (!done) begin
      vectors++; miscompares++;
      $display("[TB] FAIL word accept timeout: got no s_ready, expected accept within 300 cycles");
    end
  endtask

  task automatic wait_idle(input int budget);
    bit idle = 0;
    for (int i = 0; i < budget && !idle; i++) begin
      @(negedge core_clk);
      idle = !busy_le && !m_tvalid_le;
      if (!idle) tick();
    end
    if (!idle) begin
      vectors++; miscompares++;
      $display("[TB] FAIL idle timeout: got busy, expected idle within %0d cycles", budget);
    end
    tick(); tick();
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1; tick(); flush_i = 1'b0;
  endtask

  task automatic clear_log();
    log_le.delete(); log_be.delete(); log_last.delete(); log_cyc.delete();
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    rst_n = 1'b0; cfg_k = 8'd8; s_data = '0; s_valid = 1'b0; flush_i = 1'b0;
    m_tready = 1'b1; ev_m = 1'b0; ev_u = 1'b0;
    repeat (3) @(posedge core_clk);
    #1 rst_n = 1'b1;
    tick(); tick(); tick();

    // Two back-to-back words form one 8-byte block.
    clear_log();
    apply_stimulus(32'h03020100);
    apply_stimulus(32'h07060504);
    wait_idle(50);
    check_output("t1 count", log_le.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_output("t1 byte", log_le[i], i);
      check_output("t1 last", log_last[i], (i == 7));
    end
    for (int i = 0; i < 7; i++) check_output("t1 no bubble", log_cyc[i+1] - log_cyc[i], 1);
    check_output("t1 be first", log_be[0], 8'h03);
    check_output("t1 blk_cnt", blk_cnt_le, 1);

    // Byte order.
    cfg_k = 8'd4; tick(); tick();
    clear_log();
    apply_stimulus(32'hAABBCCDD);
    wait_idle(50);
    check_output("t2 be b0", log_be[0], 8'hAA);
    check_output("t2 be b1", log_be[1], 8'hBB);
    check_output("t2 be b3", log_be[3], 8'hDD);
    check_output("t2 le b0", log_le[0], 8'hDD);
    check_output("t2 last", log_last[3], 1);

    // Flush pads a 4-byte word out to a 5-byte block.
    cfg_k = 8'd5; tick(); tick();
    clear_log();
    apply_stimulus(32'h44332211);
    pulse_flush();
    @(negedge core_clk);
    check_output("t3 s_ready after flush", s_ready_le, 0);
    tick();
    wait_idle(50);
    check_output("t3 count", log_le.size(), 5);
    check_output("t3 b0", log_le[0], 8'h11);
    check_output("t3 b3", log_le[3], 8'h44);
    check_output("t3 pad", log_le[4], 8'h00);
    check_output("t3 last on pad", log_last[4], 1);
    check_output("t3 no early last", log_last[3], 0);
    check_output("t3 blk_cnt", blk_cnt_le, 3);

    // Flush with nothing in progress makes no block.
    clear_log();
    pulse_flush();
    tick();
    @(negedge core_clk);
    check_output("t4 busy", busy_le, 0);
    check_output("t4 no bytes", log_le.size(), 0);
    check_output("t4 blk_cnt", blk_cnt_le, 3);
    tick();

    // Block length change takes effect only at the next block.
    cfg_k = 8'd8; tick(); tick();
    clear_log();
    apply_stimulus(32'h13121110);
    cfg_k = 8'd3;
    apply_stimulus(32'h17161514);
    wait_idle(50);
    apply_stimulus(32'h1B1A1918);
    pulse_flush();
    wait_idle(50);
    check_output("t5 count", log_le.size(), 14);
    for (int i = 0; i < 14; i++) check_output("t5 last", log_last[i], (i == 7 || i == 10 || i == 13));
    check_output("t5 b11", log_le[11], 8'h1B);
    check_output("t5 pad", log_le[12], 8'h00);
    check_output("t5 blk_cnt", blk_cnt_le, 6);

    // cfg_k = 0 selects the maximum block length.
    cfg_k = 8'd0; tick(); tick();
    clear_log();
    for (int i = 0; i < 58; i++)
      apply_stimulus({8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    pulse_flush();
    wait_idle(1000);
    check_output("t6 count", log_le.size(), 458);
    check_output("t6 last 228", log_last[228], 1);
    check_output("t6 not last 227", log_last[227], 0);
    check_output("t6 b228", log_le[228], 8'hE4);
    check_output("t6 b231", log_le[231], 8'hE7);
    check_output("t6 pad", log_le[232], 8'h00);
    check_output("t6 last 457", log_last[457], 1);
    check_output("t6 blk_cnt", blk_cnt_le, 8);

    // Stall holds output stable.
    cfg_k = 8'd4; tick(); tick();
    clear_log();
    m_tready = 1'b0;
    apply_stimulus(32'hDDCCBBAA);
    m_tready = 1'b1; tick();
    m_tready = 1'b0;
    @(negedge core_clk);
    check_output("t7 stall data", m_tdata_le, 8'hBB);
    check_output("t7 stall be data", m_tdata_be, 8'hCC);
    check_output("t7 stall last", m_tlast_le, 0);
    tick();
    @(negedge core_clk);
    check_output("t7 stall data 2", m_tdata_le, 8'hBB);
    check_output("t7 stall valid", m_tvalid_le, 1);
    tick();
    m_tready = 1'b1;
    wait_idle(50);
    check_output("t7 count", log_le.size(), 4);
    check_output("t7 b1", log_le[1], 8'hBB);
    check_output("t7 last", log_last[3], 1);

    // Event counting and saturation.
    ev_m = 1'b1; ev_u = 1'b1; tick();
    ev_m = 1'b0; ev_u = 1'b0;
    @(negedge core_clk);
    check_output("t8 err +2", err_cnt_le, 2);
    tick();
    ev_m = 1'b1; ev_u = 1'b1;
    repeat (32770) tick();
    ev_m = 1'b0; ev_u = 1'b0;
    @(negedge core_clk);
    check_output("t8 err saturated", err_cnt_le, 16'hFFFF);
    tick();

    // Reset mid-block discards the partial block.
    cfg_k = 8'd8; tick(); tick();
    apply_stimulus(32'h33323130);
    tick();
    #2 rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    clear_log();
    apply_stimulus(32'h23222120);
    apply_stimulus(32'h27262524);
    wait_idle(50);
    check_output("t9 count", log_le.size(), 8);
    check_output("t9 b0", log_le[0], 8'h20);
    for (int i = 0; i < 8; i++) check_output("t9 last", log_last[i], (i == 7));
    check_output("t9 blk_cnt", blk_cnt_le, 1);
    check_output("t9 err_cnt", err_cnt_le, 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      s_valid  = ($urandom_range(0, 9) < 6);
      s_data   = $urandom();
      m_tready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 9);
        cfg_k = (r == 0) ? 8'd0 : (r == 1) ? 8'($urandom_range(230, 255)) : 8'($urandom_range(1, 12));
      end
      flush_i = ($urandom_range(0, 29) == 0);
      ev_m = ($urandom_range(0, 15) == 0);
      ev_u = ($urandom_range(0, 15) == 0);
      tick();
    end
    s_valid = 1'b0; flush_i = 1'b0; ev_m = 1'b0; ev_u = 1'b0; m_tready = 1'b1;
    pulse_flush();
    wait_idle(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
